// File: rtl/state_machine_control.sv
// Sequencer that launches the init engine, then the shuffle engine,
// and muxes whichever engine is active onto the shared memory port.
module state_machine_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic       start_init,
  input  logic       finish_init,
  output logic       start_shuffle,
  input  logic       finish_shuffle,
  input  logic       write_enable_init,
  input  logic       write_enable_shuffle,
  output logic       write_enable_out,
  input  logic [7:0] address_init,
  input  logic [7:0] address_shuffle,
  output logic [7:0] address_out,
  input  logic [7:0] write_data_init,
  input  logic [7:0] write_data_shuffle,
  output logic [7:0] write_data_out
);

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] START_INIT    = 3'd1;
  localparam logic [2:0] WAIT_INIT     = 3'd2;
  localparam logic [2:0] START_SHUFFLE = 3'd3;
  localparam logic [2:0] WAIT_SHUFFLE  = 3'd4;
  localparam logic [2:0] DONE          = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       sel_init;
  logic       sel_shuffle;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Unused encodings fall back to IDLE on the next edge.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:
        state_nxt = start ? START_INIT : IDLE;
      START_INIT:
        state_nxt = WAIT_INIT;
      WAIT_INIT:
        state_nxt = finish_init ? START_SHUFFLE : WAIT_INIT;
      START_SHUFFLE:
        state_nxt = WAIT_SHUFFLE;
      WAIT_SHUFFLE:
        state_nxt = finish_shuffle ? DONE : WAIT_SHUFFLE;
      DONE:
        state_nxt = start ? DONE : IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  assign start_init    = (state == START_INIT);
  assign start_shuffle = (state == START_SHUFFLE);
  assign finish        = (state == DONE);

  assign sel_init    = (state == START_INIT)
                     | (state == WAIT_INIT);
  assign sel_shuffle = (state == START_SHUFFLE)
                     | (state == WAIT_SHUFFLE);

  always_comb begin
    write_enable_out = 1'b0;
    address_out      = 8'h00;
    write_data_out   = 8'h00;
    unique case (1'b1)
      sel_init: begin
        write_enable_out = write_enable_init;
        address_out      = address_init;
        write_data_out   = write_data_init;
      end
      sel_shuffle: begin
        write_enable_out = write_enable_shuffle;
        address_out      = address_shuffle;
        write_data_out   = write_data_shuffle;
      end
      default: begin
        write_enable_out = 1'b0;
        address_out      = 8'h00;
        write_data_out   = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_state_machine_control.sv
// Directed bench for state_machine_control.
// Observed word: {finish,start_init,start_shuffle,we,addr,data}.
module tb_state_machine_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       finish;
  logic       start_init;
  logic       finish_init;
  logic       start_shuffle;
  logic       finish_shuffle;
  logic       write_enable_init;
  logic       write_enable_shuffle;
  logic       write_enable_out;
  logic [7:0] address_init;
  logic [7:0] address_shuffle;
  logic [7:0] address_out;
  logic [7:0] write_data_init;
  logic [7:0] write_data_shuffle;
  logic [7:0] write_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  state_machine_control dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .finish               (finish),
    .start_init           (start_init),
    .finish_init          (finish_init),
    .start_shuffle        (start_shuffle),
    .finish_shuffle       (finish_shuffle),
    .write_enable_init    (write_enable_init),
    .write_enable_shuffle (write_enable_shuffle),
    .write_enable_out     (write_enable_out),
    .address_init         (address_init),
    .address_shuffle      (address_shuffle),
    .address_out          (address_out),
    .write_data_init      (write_data_init),
    .write_data_shuffle   (write_data_shuffle),
    .write_data_out       (write_data_out)
  );

  function automatic logic [19:0] obs();
    return {finish, start_init, start_shuffle,
            write_enable_out, address_out,
            write_data_out};
  endfunction

  task automatic check(input string tag,
                       input logic [19:0] got,
                       input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                = 1'b0;
    start                = 1'b1;
    finish_init          = 1'b0;
    finish_shuffle       = 1'b0;
    write_enable_init    = 1'b1;
    write_enable_shuffle = 1'b1;
    address_init         = 8'h11;
    address_shuffle      = 8'h22;
    write_data_init      = 8'h33;
    write_data_shuffle   = 8'h44;

    // Reset, with start already high
    step();
    check("reset", obs(), 20'h0_00_00);

    reset = 1'b1;
    step();
    check("start_init", obs(), 20'h5_11_33);
    step();
    check("wait_init", obs(), 20'h1_11_33);
    start = 1'b0;

    write_data_init = 8'hFF;
    for (int a = 1; a <= 3; a++) begin
      address_init = 8'(a);
      #1;
      check("init_mux", obs(), {4'h1, 8'(a), 8'hFF});
      step();
    end

    finish_shuffle = 1'b1;
    step();
    check("shuf_in_wait_init", obs(), 20'h1_03_FF);

    finish_init = 1'b1;
    step();
    check("start_shuffle", obs(), 20'h3_22_44);
    finish_init    = 1'b0;
    finish_shuffle = 1'b0;
    step();
    check("wait_shuffle", obs(), 20'h1_22_44);

    finish_init = 1'b1;
    step();
    check("init_in_wait_shuf", obs(), 20'h1_22_44);
    finish_init = 1'b0;

    write_data_shuffle = 8'hAA;
    for (int a = 9; a >= 7; a--) begin
      address_shuffle = 8'(a);
      #1;
      check("shuf_mux", obs(), {4'h1, 8'(a), 8'hAA});
      step();
    end

    finish_shuffle = 1'b1;
    step();
    check("done", obs(), 20'h8_00_00);
    finish_shuffle = 1'b0;
    step();
    check("idle_after_done", obs(), 20'h0_00_00);
    step();
    check("idle_hold", obs(), 20'h0_00_00);

    // Held start: DONE persists, no retrigger
    address_init       = 8'h11;
    write_data_init    = 8'h33;
    address_shuffle    = 8'h22;
    write_data_shuffle = 8'h44;
    start = 1'b1;
    step();
    check("hs_start_init", obs(), 20'h5_11_33);
    step();
    check("hs_wait_init", obs(), 20'h1_11_33);
    finish_init = 1'b1;
    step();
    check("hs_start_shuf", obs(), 20'h3_22_44);
    finish_init = 1'b0;
    step();
    check("hs_wait_shuf", obs(), 20'h1_22_44);
    finish_shuffle = 1'b1;
    step();
    check("hs_done", obs(), 20'h8_00_00);
    finish_shuffle = 1'b0;
    step();
    check("hs_done_hold1", obs(), 20'h8_00_00);
    step();
    check("hs_done_hold2", obs(), 20'h8_00_00);
    start = 1'b0;
    step();
    check("hs_idle", obs(), 20'h0_00_00);

    // Reset mid-sequence
    start = 1'b1;
    step();
    check("mr_start_init", obs(), 20'h5_11_33);
    start = 1'b0;
    step();
    finish_init = 1'b1;
    step();
    finish_init = 1'b0;
    step();
    check("mr_wait_shuf", obs(), 20'h1_22_44);
    reset = 1'b0;
    step();
    check("mr_reset", obs(), 20'h0_00_00);
    reset          = 1'b1;
    finish_shuffle = 1'b1;
    step();
    check("mr_shuf_in_idle", obs(), 20'h0_00_00);
    finish_shuffle = 1'b0;
    finish_init    = 1'b1;
    step();
    check("mr_init_in_idle", obs(), 20'h0_00_00);
    finish_init = 1'b0;
    step();
    check("mr_idle", obs(), 20'h0_00_00);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/state_machine_control.md
STATE_MACHINE_CONTROL -- requirements
Module: state_machine_control

Interface
REQ-001 SHALL have the following ports: clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have the following ports: reset, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have the following ports: start, input, 1, level request to run the init-then-shuffle sequence.
REQ-004 SHALL have the following ports: finish, output, 1, sequence complete.
REQ-005 SHALL have the following ports: start_init, output, 1, one-cycle launch pulse to the init engine.
REQ-006 SHALL have the following ports: finish_init, input, 1, init engine done.
REQ-007 SHALL have the following ports: start_shuffle, output, 1, one-cycle launch pulse to the shuffle engine.
REQ-008 SHALL have the following ports: finish_shuffle, input, 1, shuffle engine done.
REQ-009 SHALL have the following ports: write_enable_init / write_enable_shuffle, input, 1 each, engine memory write enables.
REQ-010 SHALL have the following ports: write_enable_out, output, 1, muxed memory write enable.
REQ-011 SHALL have the following ports: address_init / address_shuffle, input, 8 each, engine memory addresses.
REQ-012 SHALL have the following ports: address_out, output, 8, muxed memory address.
REQ-013 SHALL have the following ports: write_data_init / write_data_shuffle, input, 8 each, engine write data.
REQ-014 SHALL have the following ports: write_data_out, output, 8, muxed write data.
REQ-015 SHALL have no parameters.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, START_INIT, WAIT_INIT, START_SHUFFLE, WAIT_SHUFFLE, DONE, held in one state register.
REQ-017 SHALL transition IDLE->START_INIT when start=1, else stay in IDLE.
REQ-018 SHALL transition START_INIT->WAIT_INIT unconditionally after one cycle.
REQ-019 SHALL transition WAIT_INIT->START_SHUFFLE when finish_init=1, else stay in WAIT_INIT.
REQ-020 SHALL transition START_SHUFFLE->WAIT_SHUFFLE unconditionally after one cycle.
REQ-021 SHALL transition WAIT_SHUFFLE->DONE when finish_shuffle=1, else stay in WAIT_SHUFFLE.
REQ-022 SHALL transition DONE->IDLE when start=0, and stay in DONE while start=1, so a held start never retriggers.
REQ-023 SHALL drive start_init=1 only in START_INIT and start_shuffle=1 only in START_SHUFFLE, giving exactly one-cycle pulses.
REQ-024 SHALL drive finish=1 only in DONE.
REQ-025 SHALL ignore finish_init in every state except WAIT_INIT, and ignore finish_shuffle in every state except WAIT_SHUFFLE.
REQ-026 SHALL ignore a finish_shuffle that arrives together with finish_init in WAIT_INIT, and SHALL ignore start in every state except IDLE and DONE.
REQ-027 SHALL route write_enable_init, address_init and write_data_init to the three outputs in START_INIT and WAIT_INIT.
REQ-028 SHALL route write_enable_shuffle, address_shuffle and write_data_shuffle to the three outputs in START_SHUFFLE and WAIT_SHUFFLE.
REQ-029 SHALL drive write_enable_out=0, address_out=8'h00 and write_data_out=8'h00 in IDLE and DONE.
REQ-030 SHALL implement the mux as purely combinational from the state register and inputs, so a mux-input change appears on the outputs in the same cycle.
REQ-031 SHALL decode all control outputs from the state register only, with no combinational path from any input.
REQ-032 SHALL pass all 8 data and address bits through unmodified, with no arithmetic.
REQ-033 SHALL treat an unreachable state encoding as IDLE on the next clock and SHALL drive IDLE outputs while in it.

Reset
REQ-034 SHALL, on a rising clk edge with reset=0, enter IDLE regardless of the current state or any input, including mid-sequence.
REQ-035 SHALL, while in reset, drive start_init=0, start_shuffle=0, finish=0, write_enable_out=0, address_out=8'h00 and write_data_out=8'h00.
REQ-036 SHALL start a new sequence only on a start=1 sampled after reset is released, and not on the edge at which reset is released.

Verification
REQ-037 SHALL pass this scenario: reset=0 for 1 cycle, then reset=1, start=1 -> start_init=1 for exactly one cycle, then WAIT_INIT, finish=0.
REQ-038 SHALL pass this scenario: in WAIT_INIT with write_data_init=8'hFF and address_init stepping 1,2,3 -> address_out follows 1,2,3 in the same cycles and write_data_out=8'hFF.
REQ-039 SHALL pass this scenario: finish_init=1 for one cycle -> start_shuffle=1 for one cycle, then with write_data_shuffle=8'hAA and address_shuffle stepping 9,8,7 -> address_out follows 9,8,7 and write_data_out=8'hAA.
REQ-040 SHALL pass this scenario: finish_shuffle=1 while start=0 -> finish=1 for one cycle, then IDLE with address_out=8'h00.
REQ-041 SHALL pass this scenario: finish_shuffle=1 while start is held at 1 -> finish stays 1 until start=0, and no second start_init pulse occurs.
REQ-042 SHALL pass this scenario: reset=0 asserted in WAIT_SHUFFLE -> next cycle all outputs at their reset values, and a finish_shuffle pulse during IDLE has no effect.
